// File: rtl/nonce_collector_if.sv
// Bus bundle between the per-slave receivers, the uplink transmitter and the
// nonce collector.
interface nonce_collector_if #(
    parameter int SLAVES    = 2,
    parameter int FIFO_LOG2 = 3
);
    logic [SLAVES*32-1:0] slave_nonces;
    logic [SLAVES-1:0]    new_nonces;
    logic                 serial_busy;
    logic                 serial_send;
    logic [31:0]          golden_nonce;
    logic [FIFO_LOG2:0]   fifo_count;
    logic [15:0]          dropped;

    modport slave (
        input  slave_nonces, new_nonces, serial_busy,
        output serial_send, golden_nonce, fifo_count, dropped
    );

    modport master (
        output slave_nonces, new_nonces, serial_busy,
        input  serial_send, golden_nonce, fifo_count, dropped
    );
endinterface

// File: rtl/nonce_collector.sv
// Latches per-slave nonces, round-robin arbitrates them into a FWFT FIFO and
// paces the FIFO head into the uplink transmitter with a send/busy handshake.
module nonce_collector #(
    parameter int SLAVES    = 2,
    parameter int FIFO_LOG2 = 3
) (
    input  logic              clk,
    input  logic              reset,
    nonce_collector_if.slave  cif
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int RR_W  = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, SEND, ACK, DRAIN} state_t;

    logic [31:0]          r_hold [SLAVES];
    logic [SLAVES-1:0]    r_pend;
    logic [RR_W-1:0]      r_rr;
    logic [31:0]          r_mem [DEPTH];
    logic [FIFO_LOG2-1:0] r_wr, r_rd;
    logic [FIFO_LOG2:0]   r_count;
    logic [15:0]          r_dropped;
    logic [31:0]          r_golden;
    logic                 r_send;
    state_t               r_state, w_state_nxt;

    logic                 w_hi_vld, w_lo_vld, w_gnt_vld;
    logic [RR_W-1:0]      w_hi_idx, w_lo_idx, w_gnt_idx;
    logic [SLAVES-1:0]    w_gnt, w_drop;
    logic [31:0]          w_push_data;
    logic                 w_full, w_empty, w_pop, w_push;
    logic [16:0]          w_drop_sum, w_drop_tot;

    assign w_full  = (r_count == (FIFO_LOG2+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = w_gnt_vld;

    // Round robin: first pending slot at or above rr, else wrap to the lowest.
    always_comb begin
        w_hi_vld = 1'b0;
        w_lo_vld = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int i = 0; i < SLAVES; i++) begin
            if (r_pend[i] && !w_lo_vld) begin
                w_lo_vld = 1'b1;
                w_lo_idx = RR_W'(i);
            end
            if (r_pend[i] && !w_hi_vld && (i >= int'(r_rr))) begin
                w_hi_vld = 1'b1;
                w_hi_idx = RR_W'(i);
            end
        end
        w_gnt_idx   = w_hi_vld ? w_hi_idx : w_lo_idx;
        w_gnt_vld   = w_lo_vld && !w_full;
        w_gnt       = '0;
        w_push_data = '0;
        for (int i = 0; i < SLAVES; i++) begin
            if (w_gnt_vld && (w_gnt_idx == RR_W'(i))) begin
                w_gnt[i]    = 1'b1;
                w_push_data = r_hold[i];
            end
        end
    end

    // A strobe on an occupied slot is lost unless that slot drains this cycle.
    always_comb begin
        w_drop     = '0;
        w_drop_sum = '0;
        for (int i = 0; i < SLAVES; i++) begin
            w_drop[i]  = cif.new_nonces[i] & r_pend[i] & ~w_gnt[i];
            w_drop_sum = w_drop_sum + 17'(w_drop[i]);
        end
        w_drop_tot = {1'b0, r_dropped} + w_drop_sum;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE:    if (!w_empty && !cif.serial_busy) begin
                         w_pop       = 1'b1;
                         w_state_nxt = SEND;
                     end
            SEND:    w_state_nxt = cif.serial_busy ? DRAIN : ACK;
            ACK:     if (cif.serial_busy) w_state_nxt = DRAIN;
            DRAIN:   if (!cif.serial_busy) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= w_push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend    <= '0;
            r_rr      <= '0;
            r_wr      <= '0;
            r_rd      <= '0;
            r_count   <= '0;
            r_dropped <= '0;
            r_golden  <= '0;
            r_send    <= 1'b0;
            r_state   <= IDLE;
            for (int i = 0; i < SLAVES; i++) r_hold[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_send  <= w_pop;
            if (w_pop) begin
                r_golden <= r_mem[r_rd];
                r_rd     <= r_rd + 1'b1;
            end
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
                r_rr <= (w_gnt_idx == RR_W'(SLAVES-1)) ? '0 : w_gnt_idx + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
            r_dropped <= w_drop_tot[16] ? 16'hFFFF : w_drop_tot[15:0];
            for (int i = 0; i < SLAVES; i++) begin
                if (w_gnt[i]) r_pend[i] <= 1'b0;
                if (cif.new_nonces[i] && (!r_pend[i] || w_gnt[i])) begin
                    r_hold[i] <= cif.slave_nonces[i*32 +: 32];
                    r_pend[i] <= 1'b1;
                end
            end
        end
    end

    assign cif.serial_send  = r_send;
    assign cif.golden_nonce = r_golden;
    assign cif.fifo_count   = r_count;
    assign cif.dropped      = r_dropped;
endmodule

// File: tb/tb_nonce_collector.sv
// Bench for nonce_collector: directed scenarios plus random traffic, with a
// queue-based reference model compared against the outputs every cycle.
module tb_nonce_collector;
    localparam int S     = 4;
    localparam int FL    = 2;
    localparam int DEPTH = 1 << FL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nonce_collector_if #(.SLAVES(S), .FIFO_LOG2(FL)) cif();
    nonce_collector #(.SLAVES(S), .FIFO_LOG2(FL)) dut (.clk(clk), .reset(rst), .cif(cif));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0] m_hold [S];
    bit          m_pend [S];
    int          m_rr, m_drop;
    logic [31:0] m_fifo [$];
    logic [31:0] m_gold;
    bit          m_send, m_ready, m_seen, m_on;
    int          cyc;

    // Observed transmit stream and transmitter model
    logic [31:0] txq [$];
    int          txc [$];
    int          push_total = 0;
    int          prev_cnt   = 0;
    int          tx_cnt = 0, tx_len = 2;
    bit          tx_arm = 0, tx_rand = 0, busy_hold = 0;

    initial begin
        m_on = 0;
        cyc  = 0;
        forever begin
            @(posedge clk);
            if (rst) cyc = 0; else cyc++;
            if (rst) begin
                for (int i = 0; i < S; i++) begin m_hold[i] = '0; m_pend[i] = 0; end
                m_rr = 0; m_drop = 0; m_fifo.delete(); m_gold = '0;
                m_send = 0; m_ready = 1; m_seen = 0; m_on = 1;
            end else if (m_on) begin
                int g, nd;
                bit pop;
                g = -1;
                if (m_fifo.size() < DEPTH)
                    for (int k = 0; k < S; k++)
                        if (g < 0 && m_pend[(m_rr + k) % S]) g = (m_rr + k) % S;
                pop = m_ready && (m_fifo.size() > 0) && !cif.serial_busy;
                m_send = pop;
                if (pop) begin
                    m_gold  = m_fifo.pop_front();
                    m_ready = 0;
                    m_seen  = 0;
                end else if (!m_ready) begin
                    if (!m_seen) m_seen = cif.serial_busy;
                    else if (!cif.serial_busy) m_ready = 1;
                end
                if (g >= 0) begin
                    m_fifo.push_back(m_hold[g]);
                    m_pend[g] = 0;
                    m_rr = (g + 1) % S;
                end
                nd = 0;
                for (int i = 0; i < S; i++)
                    if (cif.new_nonces[i]) begin
                        if (!m_pend[i]) begin
                            m_hold[i] = cif.slave_nonces[i*32 +: 32];
                            m_pend[i] = 1;
                        end else nd++;
                    end
                m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
            end
        end
    end

    // Per-cycle compare, stream capture and transmitter busy generation
    initial begin
        cif.serial_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (m_on) begin
                chk("send",  32'(cif.serial_send), 32'(m_send));
                chk("gold",  cif.golden_nonce, m_gold);
                chk("count", 32'(cif.fifo_count), 32'(m_fifo.size()));
                chk("drop",  32'(cif.dropped), 32'(m_drop));
            end
            if (cif.serial_send === 1'b1) begin
                txq.push_back(cif.golden_nonce);
                txc.push_back(cyc);
            end
            push_total += int'(cif.fifo_count) - prev_cnt + int'(cif.serial_send === 1'b1);
            prev_cnt = int'(cif.fifo_count);
            if (rst) begin
                tx_cnt = 0;
                tx_arm = 0;
            end else begin
                if (tx_cnt > 0) tx_cnt--;
                if (tx_arm) begin
                    tx_cnt = tx_rand ? int'($urandom_range(1, 5)) : tx_len;
                    tx_arm = 0;
                end
                if (cif.serial_send === 1'b1) tx_arm = 1;
            end
            cif.serial_busy = busy_hold || (tx_cnt > 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic strobe(input logic [S-1:0] m, input logic [S*32-1:0] d);
        cif.new_nonces   = m;
        cif.slave_nonces = d;
        tick();
        cif.new_nonces = '0;
    endtask

    task automatic wait_tx(input int b, input int n, input int budget);
        int k = 0;
        while ((txq.size() - b < n) && (k < budget)) begin
            tick();
            k++;
        end
        chk("wait_tx", 32'(txq.size() - b >= n), 32'd1);
    endtask

    initial begin
        int b, pb, pe, j;
        logic [S-1:0]      m;
        logic [S*32-1:0]   d;
        cif.new_nonces   = '0;
        cif.slave_nonces = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_send",  32'(cif.serial_send), 32'd0);
        chk("rst_gold",  cif.golden_nonce, 32'd0);
        chk("rst_count", 32'(cif.fifo_count), 32'd0);
        chk("rst_drop",  32'(cif.dropped), 32'd0);
        rst = 1'b0;

        // Single nonce: strobe at cycle 10, send expected at cycle 13
        do_reset();
        tx_len = 20;
        b = txq.size();
        while (cyc != 10) tick();
        strobe(4'b0001, {96'h0, 32'hDEADBEEF});
        repeat (30) tick();
        chk("single_n", 32'(txq.size() - b), 32'd1);
        if (txq.size() > b) begin
            chk("single_cyc", 32'(txc[b]), 32'd13);
            chk("single_val", txq[b], 32'hDEADBEEF);
        end
        chk("single_drop", 32'(cif.dropped), 32'd0);

        // All slaves at once, rr=0
        do_reset();
        tx_len = 2;
        b = txq.size();
        strobe(4'hF, {32'd4, 32'd3, 32'd2, 32'd1});
        wait_tx(b, 4, 200);
        if (txq.size() >= b + 4)
            for (int i = 0; i < 4; i++) chk("simul_order", txq[b+i], 32'(i + 1));
        b = txq.size();
        strobe(4'b0011, {64'h0, 32'h000000B1, 32'h000000A0});
        wait_tx(b, 2, 100);
        if (txq.size() >= b + 2) begin
            chk("follow_0", txq[b],   32'h000000A0);
            chk("follow_1", txq[b+1], 32'h000000B1);
        end

        // Fairness: slave 0 streams, slave 1 strobes once
        do_reset();
        tx_len = 1;
        b  = txq.size();
        pb = push_total;
        pe = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 12) begin
                strobe(4'b0011, {64'h0, 32'h51515151, 32'h0A000000 + 32'(k)});
                pe = push_total;
            end else begin
                strobe(4'b0001, {96'h0, 32'h0A000000 + 32'(k)});
            end
        end
        repeat (200) tick();
        j = -1;
        for (int i = b; i < txq.size(); i++) if (txq[i] == 32'h51515151) j = i - b;
        chk("fair_seen", 32'(j >= 0), 32'd1);
        chk("fair_gap", 32'((j - (pe - pb) >= 0) && (j - (pe - pb) <= 1)), 32'd1);

        // Back-pressure on a 4-deep FIFO
        busy_hold = 1;
        do_reset();
        for (int k = 0; k < 8; k++) strobe(4'b0001, {96'h0, 32'd100 + 32'(k)});
        repeat (3) tick();
        chk("bp_count", 32'(cif.fifo_count), 32'd4);
        chk("bp_drop",  32'(cif.dropped), 32'd3);
        chk("bp_pend",  32'(dut.r_pend[0]), 32'd1);
        b = txq.size();
        tx_len = 2;
        busy_hold = 0;
        wait_tx(b, 5, 300);
        repeat (30) tick();
        chk("bp_n", 32'(txq.size() - b), 32'd5);
        if (txq.size() >= b + 5)
            for (int i = 0; i < 5; i++) chk("bp_order", txq[b+i], 32'd100 + 32'(i));

        // Strobe colliding with its own grant
        do_reset();
        b = txq.size();
        strobe(4'b0001, {96'h0, 32'h000000C0});
        strobe(4'b0001, {96'h0, 32'h000000C1});
        wait_tx(b, 2, 100);
        if (txq.size() >= b + 2) begin
            chk("coll_0", txq[b],   32'h000000C0);
            chk("coll_1", txq[b+1], 32'h000000C1);
        end
        chk("coll_drop", 32'(cif.dropped), 32'd0);

        // Reset while draining with 3 words queued
        do_reset();
        tx_len = 30;
        b = txq.size();
        strobe(4'hF, {32'hE4, 32'hE3, 32'hE2, 32'hE1});
        wait_tx(b, 1, 50);
        repeat (3) tick();
        chk("rm_pre_cnt", 32'(cif.fifo_count), 32'd3);
        rst = 1'b1;
        tick();
        chk("rm_send",  32'(cif.serial_send), 32'd0);
        chk("rm_count", 32'(cif.fifo_count), 32'd0);
        chk("rm_drop",  32'(cif.dropped), 32'd0);
        chk("rm_gold",  cif.golden_nonce, 32'd0);
        rst = 1'b0;
        b = txq.size();
        repeat (40) tick();
        chk("rm_stale", 32'(txq.size() - b), 32'd0);

        // Random traffic against the model
        do_reset();
        tx_rand = 1;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < S; i++) begin
                m[i] = ($urandom_range(0, 3) == 0);
                d[i*32 +: 32] = $urandom;
            end
            if ($urandom_range(0, 99) == 0) busy_hold = !busy_hold;
            rst = ($urandom_range(0, 799) == 0);
            strobe(m, d);
        end
        rst = 1'b0;
        busy_hold = 0;
        repeat (80) tick();
        tx_rand = 0;

        // Drop counter saturation
        busy_hold = 1;
        do_reset();
        cif.new_nonces = '1;
        for (int i = 0; i < S; i++) cif.slave_nonces[i*32 +: 32] = $urandom;
        repeat (17000) tick();
        cif.new_nonces = '0;
        tick();
        chk("sat", 32'(cif.dropped), 32'h0000FFFF);
        busy_hold = 0;
        repeat (60) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
